// File: rtl/rcpu_uart_tx_if.sv
// rcpu_uart_tx_if: RCPU data-bus slice seen by the UART transmitter.
// The master drives address/data/strobes; the slave returns read data and
// its address-match flag so the core can OR-merge several peripherals.
interface rcpu_uart_tx_if;
  logic [31:0] memAddr;
  logic [15:0] memWrite;
  logic        memWE;
  logic        memRE;
  logic [15:0] memRead;
  logic        sel;

  modport master (
    output memAddr, memWrite, memWE, memRE,
    input  memRead, sel
  );

  modport slave (
    input  memAddr, memWrite, memWE, memRE,
    output memRead, sel
  );
endinterface

// File: rtl/rcpu_uart_tx.sv
// rcpu_uart_tx: memory-mapped UART transmitter on the RCPU data bus.
// Written bytes are queued in a circular FIFO and shifted out LSB first at a
// programmable bit period (DIVISOR, 0 treated as 1). Read data is purely
// combinational because the core has no wait-state input.
// Optional parity bit: define UART_TX_PARITY_EN. DIVISOR[15] then selects odd
// parity and the bit period comes from DIVISOR[14:0].
module rcpu_uart_tx #(
  parameter logic [31:0] BASE_ADDR = 32'h0000F000,
  parameter int unsigned DEPTH     = 16,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic          clk,
  input  logic          rst,
  rcpu_uart_tx_if.slave bus,
  output logic          txd
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_DIV    = 2'd2,
    REG_RSVD   = 2'd3
  } reg_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Bus decode
  logic        sel_w;
  reg_t        reg_idx;
  logic        wr_en;
  logic        push;
  logic        ovf_clr;
  logic        div_we;

  // FIFO
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic          full;
  logic          empty;
  logic          pop;
  logic          accept;
  logic          drop;
  logic          ovf_q;
  logic [7:0]    head;

  // Divisor / period selection
  logic [15:0] div_q;
  logic [15:0] div_raw;
  logic [15:0] div_period;

  // Shifter
  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] period_q, period_d;
  logic        baud_end;
  logic        txd_q, txd_d;
  logic        busy;
  logic [15:0] status;

`ifdef UART_TX_PARITY_EN
  logic par_odd;
  logic par_q, par_d;
`endif

  // Address decode and write strobes
  assign sel_w   = (bus.memAddr[31:2] == BASE_ADDR[31:2]);
  assign bus.sel = sel_w;
  assign reg_idx = reg_t'(bus.memAddr[1:0]);
  assign wr_en   = sel_w & bus.memWE;
  assign push    = wr_en && (reg_idx == REG_DATA);
  assign ovf_clr = wr_en && (reg_idx == REG_STATUS) && bus.memWrite[3];
  assign div_we  = wr_en && (reg_idx == REG_DIV);

  // FIFO status; pop only from IDLE using registered occupancy, so a byte
  // pushed into an empty FIFO is never popped in the same cycle.
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign pop    = (state_q == S_IDLE) && !empty;
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign head   = mem_q[rptr_q];

  // Bit period latched at frame start
`ifdef UART_TX_PARITY_EN
  assign div_raw = {1'b0, div_q[14:0]};
  assign par_odd = div_q[15];
`else
  assign div_raw = div_q;
`endif
  assign div_period = (div_raw == '0) ? 16'd1 : div_raw;

  // FIFO storage (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wptr_q] <= bus.memWrite[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow (a drop beats a clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // DIVISOR register
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DIV_RESET;
    end else if (div_we) begin
      div_q <= bus.memWrite;
    end
  end

  // Shifter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      period_q <= 16'd1;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      period_q <= period_d;
      txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Shifter next-state: each non-IDLE state lasts period_q clocks per bit
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    period_d = period_q;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    baud_end = (baud_q == (period_q - 16'd1));
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d  = S_START;
          shift_d  = head;
          period_d = div_period;
          baud_d   = '0;
          bitcnt_d = '0;
`ifdef UART_TX_PARITY_EN
          par_d    = (^head) ^ par_odd;
`endif
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            bitcnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d  = S_PARITY;
`else
            state_d  = S_STOP;
`endif
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // Line level derived from the next state so txd changes on the same edge
  // as the state it belongs to, while still coming straight from a flop
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign txd  = txd_q;

  assign status = {8'(count_q), 4'b0000, ovf_q, busy, empty, full};

  // Combinational read-back of pre-edge register values; 0 when unselected
  always_comb begin
    bus.memRead = '0;
    if (sel_w && bus.memRE) begin
      case (reg_idx)
        REG_STATUS: bus.memRead = status;
        REG_DIV:    bus.memRead = div_q;
        default:    bus.memRead = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rcpu_uart_tx.sv
// tb_rcpu_uart_tx: directed scenarios plus randomized bus traffic, checked
// every cycle against a frame-level behavioural model (byte queue + frame
// bit vector indexed by elapsed time / period).
module tb_rcpu_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000F000;
  localparam int unsigned DEPTH = 16;
  localparam logic [15:0] DIVR  = 16'd434;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FB = 11;
`else
  localparam int unsigned FB = 10;
`endif

  logic clk = 1'b0;
  logic rst;
  logic txd;

  rcpu_uart_tx_if bus ();

  rcpu_uart_tx #(
    .BASE_ADDR(BASE),
    .DEPTH    (DEPTH),
    .DIV_RESET(DIVR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .txd(txd)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0]  mq [$];
  logic        m_ovf;
  logic [15:0] m_div;
  bit          m_act;
  int unsigned m_pos;
  int unsigned m_p;
  logic [10:0] m_bits;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic        txd_s;
  logic [15:0] rd_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic model_txd();
    if (!m_act) return 1'b1;
    return m_bits[m_pos / m_p];
  endfunction

  function automatic logic [15:0] model_read(input logic [31:0] a, input logic re);
    logic [15:0] r;
    r = '0;
    if ((a[31:2] == BASE[31:2]) && re) begin
      case (a[1:0])
        2'd1: r = {8'(mq.size()), 4'b0000, m_ovf, m_act, (mq.size() == 0), (mq.size() == DEPTH)};
        2'd2: r = m_div;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // Advance the model across one rising edge with the given bus inputs
  task automatic model_edge(input logic r, input logic [31:0] a, input logic [15:0] wd, input logic we);
    bit sel, popping, dropping;
    int unsigned pre_size;
    logic [7:0] d;
    int unsigned per;
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_div = DIVR;
      m_act = 1'b0;
      m_pos = 0;
      m_p   = 1;
      return;
    end
    sel      = (a[31:2] == BASE[31:2]);
    pre_size = mq.size();
    popping  = !m_act && (pre_size > 0);
    dropping = 1'b0;
    if (m_act) begin
      m_pos++;
      if (m_pos == FB * m_p) m_act = 1'b0;
    end else if (popping) begin
      d = mq.pop_front();
`ifdef UART_TX_PARITY_EN
      per    = int'(m_div[14:0]);
      m_bits = {1'b1, (^d) ^ m_div[15], d, 1'b0};
`else
      per    = int'(m_div);
      m_bits = {1'b0, 1'b1, d, 1'b0};
`endif
      m_p   = (per == 0) ? 1 : per;
      m_pos = 0;
      m_act = 1'b1;
    end
    if (sel && we) begin
      case (a[1:0])
        2'd0: begin
          if (pre_size == DEPTH && !popping) dropping = 1'b1;
          else mq.push_back(wd[7:0]);
        end
        2'd1: if (wd[3]) m_ovf = 1'b0;
        2'd2: m_div = wd;
        default: ;
      endcase
    end
    if (dropping) m_ovf = 1'b1;
  endtask

  // One bus cycle: drive, compare against the model, then take the edge
  task automatic cyc(input logic r, input logic [31:0] a, input logic [15:0] wd, input logic we, input logic re);
    rst          = r;
    bus.memAddr  = a;
    bus.memWrite = wd;
    bus.memWE    = we;
    bus.memRE    = re;
    #1;
    txd_s = txd;
    rd_s  = bus.memRead;
    check("txd", txd_s, model_txd());
    check("memRead", rd_s, model_read(a, re));
    check("sel", bus.sel, (a[31:2] == BASE[31:2]));
    model_edge(r, a, wd, we);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int unsigned idx, input logic [15:0] wd);
    cyc(1'b0, BASE + 32'(idx), wd, 1'b1, 1'b0);
  endtask

  task automatic rd(input int unsigned idx);
    cyc(1'b0, BASE + 32'(idx), 16'h0000, 1'b0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [9:0]  exp_a5;
    logic        wave [22];
    logic        r;
    logic [31:0] a;
    logic [15:0] wd;
    logic        we, re;
    int unsigned idx;

    // Initial reset without comparison (DUT state unknown before it)
    rst = 1'b1;
    bus.memAddr = '0; bus.memWrite = '0; bus.memWE = 1'b0; bus.memRE = 1'b0;
    @(posedge clk);
    #1;
    model_edge(1'b1, '0, '0, 1'b0);

    // Reset state
    rd(1);
    check("reset_status", rd_s, 16'h0002);
    check("reset_txd", txd_s, 1'b1);
    rd(2);
    check("reset_divisor", rd_s, 16'd434);
    rd(3);
    check("reserved_reads_0", rd_s, 16'h0000);

`ifndef UART_TX_PARITY_EN
    // 0xA5 at 4 clocks per bit
    exp_a5 = 10'b1101001010;
    wr(2, 16'd4);
    wr(0, 16'h00A5);
    idle();
    check("a5_pre_start_txd", txd_s, 1'b1);
    for (int i = 0; i < 40; i++) begin
      idle();
      check("a5_wave", txd_s, exp_a5[i / 4]);
    end
    rd(1);
    check("a5_done_status", rd_s, 16'h0002);
`else
    // Even parity of 0x07 is 1; frame of 11 bits at 2 clocks each
    wr(2, 16'h0002);
    wr(0, 16'h0007);
    idle();
    for (int i = 0; i < 22; i++) begin
      idle();
      wave[i] = txd_s;
    end
    check("par_start", wave[0], 1'b0);
    check("par_even_bit", wave[18], 1'b1);
    check("par_stop", wave[21], 1'b1);
    rd(1);
    check("par_done_status", rd_s, 16'h0002);
    // Odd parity select
    wr(2, 16'h8002);
    wr(0, 16'h0007);
    idle();
    for (int i = 0; i < 22; i++) begin
      idle();
      wave[i] = txd_s;
    end
    check("par_odd_bit", wave[18], 1'b0);
    rd(1);
    check("par_odd_done_status", rd_s, 16'h0002);
`endif

    // Fill past DEPTH while one frame is running
    wr(2, 16'd4);
    for (int k = 0; k < 17; k++) wr(0, 16'(k));
    rd(1);
    check("fill_status", rd_s, 16'h1005);
    wr(0, 16'h00EE);
    rd(1);
    check("overflow_status", rd_s, 16'h100D);
    wr(1, 16'h0008);
    rd(1);
    check("overflow_cleared", rd_s, 16'h1005);
    cyc(1'b1, 32'h0, 16'h0, 1'b0, 1'b0);
    rd(1);
    check("flush_status", rd_s, 16'h0002);

    // Reset while data bit 3 is on the line
    wr(2, 16'd4);
    wr(0, 16'h005A);
    idle();
    for (int i = 0; i < 17; i++) idle();
    cyc(1'b1, 32'h0, 16'h0, 1'b0, 1'b0);
    rd(1);
    check("midframe_rst_status", rd_s, 16'h0002);
    check("midframe_rst_txd", txd_s, 1'b1);
    for (int i = 0; i < 8; i++) idle();

    // DIVISOR=0 acts as 1; a mid-frame change applies to the next frame only
    wr(2, 16'd0);
    wr(0, 16'h003C);
    wr(0, 16'h00C3);
    idle(); idle(); idle();
    wr(2, 16'd8);
    for (int i = 0; i < int'(FB) - 4; i++) idle();
    rd(1);
    check("div0_frame_done", rd_s, 16'h0100);
    for (int i = 0; i < 8 * int'(FB); i++) idle();
    rd(1);
    check("div8_frame_done", rd_s, 16'h0002);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      r   = ($urandom_range(0, 399) == 0);
      idx = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0) idx = 0;
      a   = ($urandom_range(0, 7) == 0) ? 32'($urandom) : BASE + 32'(idx);
      we  = ($urandom_range(0, 1) == 0);
      re  = ($urandom_range(0, 1) == 0);
      wd  = 16'($urandom);
      if (a[1:0] == 2'd2) begin
        wd = 16'($urandom_range(0, 4));
`ifdef UART_TX_PARITY_EN
        wd[15] = 1'($urandom_range(0, 1));
`endif
      end
      cyc(r, a, wd, we, re);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
